// File: rtl/inst_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller for the single-cycle decoder and ALU.
// Optional SEQ_SINGLE_STEP_EN adds step_mode: each start pulse then retires exactly one instruction.
module inst_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic        step_mode,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] inst_addr_out,
  input  logic [3:0]  dec_alu_control,
  input  logic [4:0]  dec_rd_num,
  output logic        alu_src_imm,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        busy,
  output logic        halted,
  output logic [1:0]  fault,
  output logic [31:0] retire_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RSP,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALT
  } state_t;

  localparam logic [7:0] TMO_LAST     = 8'(FETCH_TIMEOUT - 1);
  localparam logic [3:0] ALU_ILLEGAL  = 4'b1111;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [1:0] FAULT_NONE   = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  state_t      state;
  state_t      next_state;
  logic [7:0]  tmo_cnt;
  logic        stop_pend;
  logic        step_ret;
  logic        latch_inst;
  logic        busy_state;
  logic        next_busy;

`ifdef SEQ_SINGLE_STEP_EN
  assign step_ret = step_mode;
`else
  assign step_ret = 1'b0;
`endif

  assign imem_addr = pc;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start) next_state = FETCH;
      FETCH: begin
        if (imem_gnt && imem_rvalid) next_state = DECODE;
        else if (imem_gnt)           next_state = WAIT_RSP;
      end
      // A response arriving on the final allowed cycle still beats the timeout.
      WAIT_RSP: begin
        if (imem_rvalid)              next_state = DECODE;
        else if (tmo_cnt == TMO_LAST) next_state = HALT;
      end
      DECODE:    next_state = EXECUTE;
      EXECUTE:   next_state = (dec_alu_control == ALU_ILLEGAL) ? HALT : WRITEBACK;
      WRITEBACK: next_state = (stop_pend || stop || step_ret) ? IDLE : FETCH;
      HALT:      next_state = HALT;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    latch_inst = ((state == FETCH) && imem_gnt && imem_rvalid) ||
                 ((state == WAIT_RSP) && imem_rvalid);
    busy_state = (state != IDLE) && (state != HALT);
    next_busy  = (next_state != IDLE) && (next_state != HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      imem_req <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      rf_we    <= 1'b0;
    end else begin
      state    <= next_state;
      imem_req <= (next_state == FETCH);
      busy     <= next_busy;
      halted   <= (next_state == HALT);
      rf_we    <= (state == EXECUTE) && (next_state == WRITEBACK) && (dec_rd_num != 5'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_out      <= '0;
      inst_addr_out <= '1;
      alu_src_imm   <= 1'b0;
    end else begin
      if (latch_inst) begin
        inst_out      <= imem_rdata;
        inst_addr_out <= pc;
      end
      if (state == DECODE) begin
        alu_src_imm <= (inst_out[6:0] == OPC_OP_IMM);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == FETCH) begin
      tmo_cnt <= '0;
    end else if (state == WAIT_RSP) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // stop is remembered from any busy state until the current instruction retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_pend <= 1'b0;
    end else if (state == WRITEBACK) begin
      stop_pend <= 1'b0;
    end else if ((state == IDLE) && start && stop) begin
      stop_pend <= 1'b1;
    end else if (busy_state && stop) begin
      stop_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      retire_count <= '0;
    end else if (state == WRITEBACK) begin
      pc           <= pc + 32'd4;
      retire_count <= retire_count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault <= FAULT_NONE;
    end else if ((state == EXECUTE) && (next_state == HALT)) begin
      fault <= FAULT_ILLEGAL;
    end else if ((state == WAIT_RSP) && (next_state == HALT)) begin
      fault <= FAULT_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed and randomized checks of inst_sequencer against a transaction-level model.
module tb_inst_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned TMO    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] inst_addr_out;
  logic [3:0]  dec_alu_control;
  logic [4:0]  dec_rd_num;
  logic        alu_src_imm;
  logic        rf_we;
  logic [31:0] pc;
  logic        busy;
  logic        halted;
  logic [1:0]  fault;
  logic [31:0] retire_count;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step_mode = 1'b0;
`endif

  inst_sequencer #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(step_mode),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_out(inst_out), .inst_addr_out(inst_addr_out),
    .dec_alu_control(dec_alu_control), .dec_rd_num(dec_rd_num),
    .alu_src_imm(alu_src_imm), .rf_we(rf_we), .pc(pc), .busy(busy),
    .halted(halted), .fault(fault), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  // Stand-in decoder: all-ones word is illegal, otherwise funct3 selects the ALU op.
  always_comb begin
    dec_alu_control = (inst_out == 32'hFFFF_FFFF) ? 4'b1111 : {1'b0, inst_out[14:12]};
    dec_rd_num      = inst_out[11:7];
  end

  int checks = 0;
  int errors = 0;
  int we_count = 0;

  always @(negedge clk) if (rf_we === 1'b1) we_count++;

  // Transaction-level model state
  logic [31:0] m_pc;
  logic [31:0] m_retire;
  int          m_we = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    tick; tick;
    rst = 1'b0;
    tick;
    m_pc = RST_PC;
    m_retire = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, RST_PC);
    chk({tag, "_inst"}, inst_out, 32'h0);
    chk({tag, "_iaddr"}, inst_addr_out, 32'hFFFF_FFFF);
    chk({tag, "_retire"}, retire_count, 32'h0);
    chk({tag, "_fault"}, 32'(fault), 32'h0);
    chk1({tag, "_req"}, imem_req, 1'b0);
    chk1({tag, "_we"}, rf_we, 1'b0);
    chk1({tag, "_imm"}, alu_src_imm, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_halted"}, halted, 1'b0);
  endtask

  // Serves one fetch: gw cycles before grant; rl=0 -> response with grant,
  // otherwise response in the rl-th cycle after the grant.
  task automatic fetch(input int unsigned gw, input int unsigned rl, input logic [31:0] w);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk1("req_seen", imem_req, 1'b1);
    chk("imem_addr", imem_addr, m_pc);
    for (int unsigned i = 0; i < gw; i++) begin
      tick;
      chk1("req_hold", imem_req, 1'b1);
    end
    imem_gnt    = 1'b1;
    imem_rvalid = (rl == 0);
    imem_rdata  = (rl == 0) ? w : $urandom;
    tick;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if (rl != 0) begin
      chk1("req_drop", imem_req, 1'b0);
      for (int unsigned i = 1; i < rl; i++) begin
        imem_rdata = $urandom;
        tick;
      end
      imem_rvalid = 1'b1;
      imem_rdata  = w;
      tick;
      imem_rvalid = 1'b0;
    end
    imem_rdata = $urandom;
  endtask

  task automatic run_instr(input int unsigned gw, input int unsigned rl, input logic [31:0] w,
                           input bit stop_mid, input bit stray_start, input bit expect_idle);
    logic [4:0] rd;
    rd = w[11:7];
    fetch(gw, rl, w);
    chk("inst_out", inst_out, w);
    chk("inst_addr", inst_addr_out, m_pc);
    chk1("busy_dec", busy, 1'b1);
    stop  = stop_mid;
    start = stray_start;
    tick;
    stop  = 1'b0;
    start = 1'b0;
    chk1("alu_src_imm", alu_src_imm, w[6:0] == 7'h13);
    tick;
    if (w == 32'hFFFF_FFFF) begin
      chk1("ill_halted", halted, 1'b1);
      chk("ill_fault", 32'(fault), 32'h1);
      chk("ill_pc", pc, m_pc);
      chk1("ill_we", rf_we, 1'b0);
      chk1("ill_busy", busy, 1'b0);
    end else begin
      chk1("rf_we", rf_we, rd != 5'd0);
      if (rd != 5'd0) m_we++;
      chk("pc_in_wb", pc, m_pc);
      tick;
      m_pc     = m_pc + 32'd4;
      m_retire = m_retire + 32'd1;
      chk("pc", pc, m_pc);
      chk("retire", retire_count, m_retire);
      chk1("we_clear", rf_we, 1'b0);
      chk("fault_none", 32'(fault), 32'h0);
      chk1("busy_after", busy, !expect_idle);
      chk1("req_after", imem_req, !expect_idle);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int unsigned gw;
    int unsigned rl;

    // Reset, stray rvalid and lone stop in IDLE do nothing
    do_reset;
    chk_reset_vals("rst");
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; stop = 1'b1;
    tick;
    imem_rvalid = 1'b0; stop = 1'b0;
    tick;
    chk1("idle_busy", busy, 1'b0);
    chk("idle_inst", inst_out, 32'h0);

    // addi x1,x0,5 with zero-wait memory; stop in IDLE must not have been latched
    start = 1'b1;
    tick;
    start = 1'b0;
    chk1("req_at_start", imem_req, 1'b1);
    run_instr(0, 0, 32'h0050_0093, 1'b0, 1'b0, 1'b0);

    // Three adds, response one cycle late, stop during the third
    do_reset;
    start = 1'b1; tick; start = 1'b0;
    run_instr(0, 1, 32'h0020_80B3, 1'b0, 1'b0, 1'b0);
    run_instr(0, 1, 32'h0020_8133, 1'b0, 1'b1, 1'b0);
    run_instr(0, 1, 32'h0020_81B3, 1'b1, 1'b0, 1'b1);
    tick; tick;
    chk1("stop_idle", busy, 1'b0);
    chk1("stop_noreq", imem_req, 1'b0);
    chk("stop_pc", pc, 32'd12);
    chk("stop_retire", retire_count, 32'd3);

    // start+stop together in IDLE runs exactly one instruction
    start = 1'b1; stop = 1'b1; tick; start = 1'b0; stop = 1'b0;
    run_instr(1, 0, 32'h0020_8233, 1'b0, 1'b0, 1'b1);

    // addi, add x0 (no write), then illegal at pc=8 halts stickily
    do_reset;
    start = 1'b1; tick; start = 1'b0;
    run_instr(0, 0, 32'h0050_0293, 1'b0, 1'b0, 1'b0);
    run_instr(0, 2, 32'h0020_8033, 1'b0, 1'b0, 1'b0);
    run_instr(0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    start = 1'b1; imem_rvalid = 1'b1; tick; start = 1'b0; imem_rvalid = 1'b0;
    tick; tick;
    chk1("halt_sticky", halted, 1'b1);
    chk1("halt_noreq", imem_req, 1'b0);
    chk("halt_pc", pc, 32'd8);
    chk("halt_fault", 32'(fault), 32'h1);
    chk("halt_retire", retire_count, 32'd2);

    // Grant without response times out after TMO cycles
    do_reset;
    start = 1'b1; tick; start = 1'b0;
    imem_gnt = 1'b1; tick; imem_gnt = 1'b0;
    repeat (TMO - 1) tick;
    chk1("tmo_not_yet", halted, 1'b0);
    chk1("tmo_busy", busy, 1'b1);
    tick;
    chk1("tmo_halted", halted, 1'b1);
    chk("tmo_fault", 32'(fault), 32'h2);
    chk("tmo_pc", pc, RST_PC);
    chk1("tmo_busy_off", busy, 1'b0);

    // Response on the last allowed cycle retires normally
    do_reset;
    start = 1'b1; tick; start = 1'b0;
    run_instr(2, TMO, 32'h0070_0093, 1'b0, 1'b0, 1'b0);

    // Reset during WAIT_RSP, then a late response for the abandoned fetch
    do_reset;
    start = 1'b1; tick; start = 1'b0;
    imem_gnt = 1'b1; tick; imem_gnt = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    chk_reset_vals("async");
    tick;
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    tick;
    imem_rvalid = 1'b0;
    tick; tick;
    chk1("abandon_busy", busy, 1'b0);
    chk("abandon_inst", inst_out, 32'h0);
    chk("abandon_pc", pc, RST_PC);

    // Randomized instruction stream
    do_reset;
    start = 1'b1; tick; start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      gw = $urandom_range(0, 3);
      rl = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1)
        w = {12'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h13};
      else
        w = {7'h00, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h33};
      run_instr(gw, rl, w, k == 29, 1'($urandom), k == 29);
    end
    tick;
    chk("rand_pc", pc, m_pc);
    chk("rand_retire", retire_count, m_retire);
    chk1("rand_idle", busy, 1'b0);
    chk("we_total", 32'(we_count), 32'(m_we));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
